// File: rtl/serial_alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: ALU function codes
// and controller state encoding.
package serial_alu_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_alu_ctrl_onebitalu.sv
// One-bit ALU slice: AND, OR, full add. z carries the adder carry and is
// held low for the logic functions and the reserved code.
module onebitALU
    import serial_alu_pkg::*;
(
    output logic y,
    output logic z,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic c0,
    input  logic c1
);

    always_comb begin
        y = 1'b0;
        z = 1'b0;
        case ({c1, c0})
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_ADD: begin
                y = a ^ b ^ cin;
                z = (a & b) | (cin & (a ^ b));
            end
            default: begin
                y = 1'b0;
                z = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer: streams WIDTH-bit operands LSB first through one
// onebitALU, recirculating its carry and assembling the result word.
//
// state  | meaning
// S_IDLE | waiting for start; result/cout hold the last operation
// S_RUN  | one operand bit per clock through the ALU, cnt = bit index
// S_DONE | done pulse; result/cout valid, start ignored
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh, b_sh, result_q, result_nxt;
    logic [1:0]       op_q;
    logic             carry_q, cout_q;
    logic             alu_y, alu_z;
    logic             last_bit;

    onebitALU u_alu (alu_y, alu_z, a_sh[0], b_sh[0], carry_q, op_q[0], op_q[1]);

    assign last_bit = (cnt_q == CNT_LAST);

    // Shift-in from the top; written this way so WIDTH=1 needs no special case.
    always_comb begin
        result_nxt            = result_q >> 1;
        result_nxt[WIDTH-1]   = alu_y;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        op_q     <= op;
                        carry_q  <= cin0;
                        cnt_q    <= '0;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    result_q <= result_nxt;
                    carry_q  <= alu_z;
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    // cnt parks at the last index instead of wrapping
                    if (last_bit) cout_q <= alu_z;
                    else          cnt_q  <= cnt_q + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed test of serial_alu_ctrl (WIDTH=8): arithmetic/logic results,
// done latency and width, start protocol and reset abort.
module tb_serial_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] a, b;
    logic       cin0;
    logic       busy, done, cout;
    logic [7:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    serial_alu_ctrl #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cin0   (cin0),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the first negedge after the accepting edge (cycle 1).
    // Returns the cycle index at which done is seen, 0 on timeout.
    task automatic wait_done(output int cyc);
        int c;
        c = 1;
        while (!done && c < 30) begin
            @(negedge clk);
            c++;
        end
        cyc = done ? c : 0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] aa,
                          input logic [7:0] bb, input logic c,
                          input logic [7:0] er, input logic ec);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb; cin0 = c;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin0 = 1'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(cyc);
        check({tag, "_latency"}, 32'(cyc), 32'd9);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(result), 32'(er));
    endtask

    initial begin
        int cyc, cnt, d1, d2, ndone;

        // Reset with start asserted: nothing accepted.
        rst_n = 1'b0; start = 1'b1; op = 2'b10; a = 8'h11; b = 8'h22; cin0 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'h00);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);

        run_op("add_5a_3c", 2'b10, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_op("add_ff_01", 2'b10, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("add_cin0",  2'b10, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        run_op("and_f0_cc", 2'b00, 8'hF0, 8'hCC, 1'b0, 8'hC0, 1'b0);
        run_op("or_f0_cc",  2'b01, 8'hF0, 8'hCC, 1'b0, 8'hFC, 1'b0);
        run_op("add_7f_01", 2'b10, 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0);

        // Start pulsed during RUN cycle 3 with other operands: ignored.
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'h5A; b = 8'h3C; cin0 = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = 2'b01; a = 8'hAA; b = 8'h55; cin0 = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 4;
        while (!done && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        check("ign_latency", 32'(cnt), 32'd9);
        check("ign_result", 32'(result), 32'h96);
        @(negedge clk);
        @(negedge clk);
        check("ign_no_restart", 32'(busy), 32'd0);

        // Start held high: operations back to back every 10 cycles.
        start = 1'b1; op = 2'b10; a = 8'h12; b = 8'h34; cin0 = 1'b0;
        d1 = 0; d2 = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                if (d1 == 0) d1 = i;
                else if (d2 == 0) d2 = i;
                check("held_result", 32'(result), 32'h46);
            end
        end
        start = 1'b0;
        check("held_first_done", 32'(d1), 32'd9);
        check("held_period", 32'(d2 - d1), 32'd10);
        cnt = 0;
        while (busy && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("held_drain", 32'(busy), 32'd0);

        // Reset during RUN cycle 4 aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'hFF; b = 8'hFF; cin0 = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'h00);
        check("abort_cout", 32'(cout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);

        run_op("add_after_abort", 2'b10, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial sequencer for the team's `onebitALU`. It accepts one WIDTH-bit operation per request and pushes the operands through a single instance of `onebitALU`, one bit per clock, LSB first. It registers the ALU carry output `z` and feeds it back as the next bit's `cin`, and assembles the result word. It sits between a requester (CPU or test sequencer) and the 1-bit ALU, so narrow ALU hardware can serve word-wide operations.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥1)

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- op  in  2  ALU function, driven to `onebitALU` as {c1,c0}
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- cin0  in  1  carry-in for bit 0, captured on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; result/cout valid
- result  out  WIDTH  assembled result; holds until next accepted start
- cout  out  1  `z` of bit WIDTH-1; holds with result

## Operation
- Op encoding {c1,c0}:
  - 2'b00 AND
  - 2'b01 OR
  - 2'b10 full add (y=sum, z=carry)
  - 2'b11 reserved; passed through unchanged.
- The controller never interprets op. It captures `z` as the carry for every op.
- States:
  - IDLE → RUN on start=1. Latch a, b, op into shift/hold registers; carry←cin0; cnt←0; clear result and cout.
  - RUN: ALU inputs are a_sh[0], b_sh[0], carry, op_q. Each edge:
    - result ← {y, result[WIDTH-1:1]}
    - carry ← z
    - a_sh, b_sh shift right
    - cnt++
  - RUN → DONE on the edge where cnt==WIDTH-1. cout←z on that edge.
  - DONE → IDLE unconditionally after one cycle. done=1 only in DONE.
- start is ignored in RUN and DONE; no queueing. A start held high through DONE is accepted in the following IDLE cycle.
- Operand inputs are don't-care except on the accepting edge.
- WIDTH=1: RUN lasts one cycle.
- cnt width is max(1, $clog2(WIDTH)). No wrap-around: cnt never exceeds WIDTH-1.
- All outputs are registered or decoded from state only; no combinational path from inputs.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, busy=0, done=0, result=0, cout=0, carry=0, cnt=0.
- Reset mid-RUN or in DONE aborts with no done pulse. The next start after rst_n=1 operates normally.
- Start accepted at edge E0. busy=1 from E0 through edge E0+WIDTH+1.
- done=1 during the cycle after edge E0+WIDTH, i.e. latency WIDTH+1 cycles start-to-done.
- Throughput: one operation per WIDTH+2 cycles, counting the mandatory IDLE cycle.
- reset and start asserted in the same cycle: reset wins.

## Structure
- Package `serial_alu_pkg`:
  - op localparams: OP_AND, OP_OR, OP_ADD, OP_RSVD
  - state enum: S_IDLE, S_RUN, S_DONE (2-bit)
- One sub-module: the existing `onebitALU`, instantiated once, with positional ports (y, z, a, b, cin, c0, c1).
- Controller FSM, counter, shift registers and carry flop are inline in `serial_alu_ctrl`.

## Test plan
- Reset: rst_n=0 for 2 cycles with start=1 → busy=0, done=0, result=8'h00, cout=0; no acceptance.
- ADD, WIDTH=8: a=8'h5A, b=8'h3C, cin0=0 → result=8'h96, cout=0; done exactly 9 cycles after the accepting edge, for exactly 1 cycle.
- ADD carry chain:
  - 8'hFF+8'h01, cin0=0 → result=8'h00, cout=1
  - 8'h00+8'h00, cin0=1 → result=8'h01, cout=0
- AND/OR: a=8'hF0, b=8'hCC → AND 8'hC0, OR 8'hFC, cout=0.
- Protocol: start pulsed at RUN cycle 3 with different operands → ignored, first result unchanged. start held high continuously → operations start every 10 cycles.
- Abort: rst_n=0 for one cycle at RUN cycle 4 → no done, outputs zero. Following ADD 8'h01+8'h01 → 8'h02.
